// File: rtl/mc_datapath_xm.sv
// Multi-cycle RISC-V datapath: PC/instruction registers, register file,
// immediate generator, ALU, non-architectural latches and an iterative
// shift-add multiplier (MUL/MULH/MULHSU/MULHU) with a start/busy/done handshake.
// ALUControl: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt,
//             0110 sll, 0111 srl, 1000 sra, 1001 sltu, others give 0.
module mc_datapath_xm #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            AdrSrc,
    input  logic            IRWrite,
    input  logic            RegWrite,
    input  logic [2:0]      ImmSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [3:0]      ALUControl,
    input  logic [1:0]      ResultSrc,
    input  logic            ABWrite,
    input  logic            OutWrite,
    input  logic            DataWrite,
    input  logic            MulStart,
    input  logic [1:0]      MulOp,
    input  logic [XLEN-1:0] ReadData,
    output logic [XLEN-1:0] Adr,
    output logic [XLEN-1:0] WriteData,
    output logic [31:0]     Instr,
    output logic            Zero,
    output logic            MulBusy,
    output logic            MulDone
);

    localparam int         RW        = $clog2(NREGS);
    localparam int         SW        = $clog2(XLEN);
    localparam int         CW        = SW + 1;
    localparam logic [5:0] NREGS_LIM = 6'(NREGS);

    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

    logic [XLEN-1:0] pc_q, pc_d, old_pc_q, old_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, data_q, data_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;
    logic [31:0]     imm32;
    logic [4:0]      rs1, rs2, rd;

    mul_state_e        mul_state_q;
    logic [2*XLEN-1:0] mul_acc_q, mul_acc_step, mul_prod;
    logic [XLEN-1:0]   mul_addend_q, mul_add, mul_result_q, a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [CW-1:0]     mul_cnt_q;
    logic              mul_neg_q, mul_high_q, mul_busy_q, mul_done_q;
    logic              a_neg, b_neg;

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign rd  = instr_q[11:7];

    // Register file read: x0 and indices beyond NREGS read as zero, no bypass
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0 && {1'b0, rs1} < NREGS_LIM) rd1 = rf_q[rs1[RW-1:0]];
        if (rs2 != 5'd0 && {1'b0, rs2} < NREGS_LIM) rd2 = rf_q[rs2[RW-1:0]];
    end

    // Register file write; x0 and out-of-range targets are dropped
    // NOTE: the register file has no reset so it maps onto plain RAM; software initialises it.
    always_ff @(posedge clk) begin
        if (RegWrite && rd != 5'd0 && {1'b0, rd} < NREGS_LIM) rf_q[rd[RW-1:0]] <= result;
    end

    // Immediate generator; every format is sign-extended from bit 31
    always_comb begin
        case (ImmSrc)
            3'b000:  imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
            3'b001:  imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            3'b010:  imm32 = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
            3'b011:  imm32 = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
            3'b100:  imm32 = {instr_q[31:12], 12'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    // Operand select, ALU and result select
    always_comb begin
        case (ALUSrcA)
            2'b00:   src_a = pc_q;
            2'b01:   src_a = old_pc_q;
            2'b10:   src_a = a_q;
            default: src_a = '0;
        endcase
        case (ALUSrcB)
            2'b00:   src_b = b_q;
            2'b01:   src_b = imm_ext;
            2'b10:   src_b = XLEN'(4);
            default: src_b = '0;
        endcase
        case (ALUControl)
            4'b0000: alu_result = src_a + src_b;
            4'b0001: alu_result = src_a - src_b;
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0100: alu_result = src_a ^ src_b;
            4'b0101: alu_result = XLEN'($signed(src_a) < $signed(src_b));
            4'b0110: alu_result = src_a << src_b[SW-1:0];
            4'b0111: alu_result = src_a >> src_b[SW-1:0];
            4'b1000: alu_result = $signed(src_a) >>> src_b[SW-1:0];
            4'b1001: alu_result = XLEN'(src_a < src_b);
            default: alu_result = '0;
        endcase
        case (ResultSrc)
            2'b00:   result = alu_out_q;
            2'b01:   result = data_q;
            2'b10:   result = alu_result;
            default: result = mul_result_q;
        endcase
    end

    assign Zero      = (alu_result == '0);
    assign Adr       = AdrSrc ? result : pc_q;
    assign WriteData = b_q;
    assign Instr     = instr_q;
    assign MulBusy   = mul_busy_q;
    assign MulDone   = mul_done_q;

    // Next-state of the enable-gated datapath registers
    // NOTE: every _d gets its hold value first so no branch can leave it unassigned (no latch).
    always_comb begin
        pc_d      = pc_q;
        old_pc_d  = old_pc_q;
        instr_d   = instr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        data_d    = data_q;
        if (PCWrite) pc_d = result;
        if (IRWrite) begin
            old_pc_d = pc_q;
            instr_d  = ReadData[31:0];
        end
        if (ABWrite) begin
            a_d = rd1;
            b_d = rd2;
        end
        if (OutWrite)  alu_out_d = alu_result;
        if (DataWrite) data_d    = ReadData;
    end

    // Datapath registers
    // NOTE: sequential state uses <= so every flop samples pre-edge values (OldPC gets the old PC).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            old_pc_q  <= '0;
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            data_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            old_pc_q  <= old_pc_d;
            instr_q   <= instr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            data_q    <= data_d;
        end
    end

    // Multiplier operand magnitudes and one shift-add step
    always_comb begin
        a_neg        = ((MulOp == 2'b01) || (MulOp == 2'b10)) && a_q[XLEN-1];
        b_neg        = (MulOp == 2'b01) && b_q[XLEN-1];
        a_mag        = a_neg ? ('0 - a_q) : a_q;
        b_mag        = b_neg ? ('0 - b_q) : b_q;
        mul_add      = mul_acc_q[0] ? mul_addend_q : '0;
        mul_sum      = {1'b0, mul_acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
        mul_acc_step = {mul_sum, mul_acc_q[XLEN-1:1]};
        mul_prod     = mul_neg_q ? ('0 - mul_acc_q) : mul_acc_q;
    end

    // Multiplier FSM: low half of the accumulator holds |A|, consumed LSB-first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_state_q  <= MUL_IDLE;
            mul_acc_q    <= '0;
            mul_addend_q <= '0;
            mul_cnt_q    <= '0;
            mul_neg_q    <= 1'b0;
            mul_high_q   <= 1'b0;
            mul_busy_q   <= 1'b0;
            mul_done_q   <= 1'b0;
            mul_result_q <= '0;
        end else begin
            mul_done_q <= 1'b0;
            case (mul_state_q)
                MUL_IDLE: begin
                    if (MulStart) begin
                        mul_acc_q    <= {{XLEN{1'b0}}, a_mag};
                        mul_addend_q <= b_mag;
                        mul_neg_q    <= a_neg ^ b_neg;
                        mul_high_q   <= (MulOp != 2'b00);
                        mul_cnt_q    <= '0;
                        mul_busy_q   <= 1'b1;
                        mul_state_q  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    mul_acc_q <= mul_acc_step;
                    mul_cnt_q <= mul_cnt_q + 1'b1;
                    if (mul_cnt_q == CW'(XLEN - 1)) mul_state_q <= MUL_DONE;
                end
                MUL_DONE: begin
                    mul_result_q <= mul_high_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
                    mul_done_q   <= 1'b1;
                    mul_busy_q   <= 1'b0;
                    mul_state_q  <= MUL_IDLE;
                end
                default: mul_state_q <= MUL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath_xm.sv
// Directed bench for mc_datapath_xm (XLEN=32, NREGS=16, RESET_PC=0x100).
// A transaction-level model tracks the architectural/latched state and the
// multiplier as "product appears XLEN+1 cycles after start"; a compare process
// checks every output against it on each falling edge.
module tb_mc_datapath_xm;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, AdrSrc, IRWrite, RegWrite, ABWrite, OutWrite, DataWrite, MulStart;
    logic [2:0]  ImmSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, MulOp;
    logic [3:0]  ALUControl;
    logic [31:0] ReadData, Adr, WriteData, Instr;
    logic        Zero, MulBusy, MulDone;

    int n_tests = 0;
    int n_fail  = 0;

    mc_datapath_xm #(.XLEN(32), .NREGS(16), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ResultSrc(ResultSrc), .ABWrite(ABWrite), .OutWrite(OutWrite),
        .DataWrite(DataWrite), .MulStart(MulStart), .MulOp(MulOp), .ReadData(ReadData),
        .Adr(Adr), .WriteData(WriteData), .Instr(Instr), .Zero(Zero), .MulBusy(MulBusy),
        .MulDone(MulDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_oldpc, m_instr, m_a, m_b, m_out, m_data, m_mulres, m_pend;
    logic [31:0] m_rf [32];
    logic        m_busy, m_done;
    int          m_cnt;

    function automatic logic [31:0] m_rd(input logic [4:0] i);
        return (i == 5'd0 || i >= 5'd16) ? 32'd0 : m_rf[i];
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] w);
        logic [31:0] t;
        case (ImmSrc)
            3'd0: return $signed(w) >>> 20;
            3'd1: return (($signed(w) >>> 20) & ~32'h1F) | {27'd0, w[11:7]};
            3'd2: begin
                t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'd0};
                return $signed(t) >>> 19;
            end
            3'd3: begin
                t = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'd0};
                return $signed(t) >>> 11;
            end
            3'd4: return w & 32'hFFFFF000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_alu();
        logic [31:0] x, y;
        x = (ALUSrcA == 2'd0) ? m_pc : (ALUSrcA == 2'd1) ? m_oldpc : (ALUSrcA == 2'd2) ? m_a : 32'd0;
        y = (ALUSrcB == 2'd0) ? m_b : (ALUSrcB == 2'd1) ? m_imm(m_instr) : (ALUSrcB == 2'd2) ? 32'd4 : 32'd0;
        case (ALUControl)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6: return x << y[4:0];
            4'd7: return x >> y[4:0];
            4'd8: return $signed(x) >>> y[4:0];
            4'd9: return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_result();
        case (ResultSrc)
            2'd0: return m_out;
            2'd1: return m_data;
            2'd2: return m_alu();
            default: return m_mulres;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [31:0] res, aluv, r1, r2;
        logic signed [63:0] sa, sb, p;
        if (!reset) begin
            m_pc = RPC; m_oldpc = 0; m_instr = 0; m_a = 0; m_b = 0; m_out = 0; m_data = 0;
            m_mulres = 0; m_busy = 0; m_done = 0; m_cnt = 0;
        end else begin
            res  = m_result();
            aluv = m_alu();
            r1   = m_rd(m_instr[19:15]);
            r2   = m_rd(m_instr[24:20]);
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_mulres = m_pend;
                end
            end else if (MulStart) begin
                sa = (MulOp == 2'd1 || MulOp == 2'd2) ? {{32{m_a[31]}}, m_a} : {32'd0, m_a};
                sb = (MulOp == 2'd1) ? {{32{m_b[31]}}, m_b} : {32'd0, m_b};
                p  = sa * sb;
                m_pend = (MulOp == 2'd0) ? p[31:0] : p[63:32];
                m_busy = 1'b1;
                m_cnt  = 33;
            end
            if (RegWrite && m_instr[11:7] != 5'd0 && m_instr[11:7] < 5'd16) m_rf[m_instr[11:7]] = res;
            if (ABWrite) begin m_a = r1; m_b = r2; end
            if (OutWrite) m_out = aluv;
            if (DataWrite) m_data = ReadData;
            if (IRWrite) begin m_oldpc = m_pc; m_instr = ReadData; end
            if (PCWrite) m_pc = res;
        end
    end

    // Compare process: all outputs against the model on every falling edge
    always @(negedge clk) begin
        check("adr",        Adr,            AdrSrc ? m_result() : m_pc);
        check("write_data", WriteData,      m_b);
        check("instr",      Instr,          m_instr);
        check("zero",       32'(Zero),      (m_alu() == 32'd0) ? 32'd1 : 32'd0);
        check("mul_busy",   32'(MulBusy),   32'(m_busy));
        check("mul_done",   32'(MulDone),   32'(m_done));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        PCWrite = 0; AdrSrc = 0; IRWrite = 0; RegWrite = 0; ImmSrc = 0; ALUSrcA = 0;
        ALUSrcB = 0; ALUControl = 0; ResultSrc = 0; ABWrite = 0; OutWrite = 0;
        DataWrite = 0; MulStart = 0;
    endtask

    task automatic view(input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] imm,
                        input logic [1:0] rsrc);
        ALUSrcA = sa; ALUSrcB = sb; ImmSrc = imm; ALUControl = 0; ResultSrc = rsrc; AdrSrc = 1;
        #1;
    endtask

    task automatic load_ir(input logic [31:0] w);
        idle(); ReadData = w; IRWrite = 1; cyc(); IRWrite = 0;
    endtask

    task automatic load_u(input logic [4:0] rd, input logic [19:0] v);
        load_ir({v, rd, 7'h37});
        ALUSrcA = 2'd3; ALUSrcB = 2'd1; ImmSrc = 3'd4; ResultSrc = 2'd2; RegWrite = 1;
        cyc(); idle();
    endtask

    task automatic exec_addi(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] imm);
        load_ir({imm, rs, 3'b000, rd, 7'h13});
        ABWrite = 1; cyc(); ABWrite = 0;
        ALUSrcA = 2'd2; ALUSrcB = 2'd1; ImmSrc = 3'd0; ALUControl = 4'd0; OutWrite = 1;
        cyc(); OutWrite = 0;
        ResultSrc = 2'd0; RegWrite = 1; cyc(); idle();
    endtask

    task automatic load_ab(input logic [4:0] r1, input logic [4:0] r2);
        load_ir({7'd1, r2, r1, 3'b000, 5'd1, 7'h33});
        ABWrite = 1; cyc(); idle();
    endtask

    task automatic read_reg(input logic [4:0] rs, output logic [31:0] v);
        load_ab(rs, 5'd0);
        view(2'd2, 2'd3, 3'd0, 2'd2);
        v = Adr;
    endtask

    task automatic run_mul(input logic [1:0] op, input int pulse, output int lat, output int dones);
        idle(); MulOp = op; MulStart = 1; cyc(); MulStart = 0;
        lat = 0; dones = 0;
        for (int k = 1; k <= 45; k++) begin
            MulStart = (pulse != 0 && k == pulse);
            IRWrite  = (pulse != 0 && k == pulse + 1);
            ABWrite  = (pulse != 0 && k == pulse + 2);
            if (pulse != 0) ReadData = 32'h00108033;
            cyc();
            if (MulDone) begin
                dones++;
                if (lat == 0) lat = k;
            end
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int lat, dones;
        logic [31:0] alu_exp [16];
        reset = 0; MulOp = 0; ReadData = 0; idle();
        cyc(); cyc();
        // reset state
        check("rst_pc", Adr, 32'h100);
        check("rst_wdata", WriteData, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_busy", 32'(MulBusy), 32'h0);
        view(2'd2, 2'd3, 3'd0, 2'd2);
        check("rst_a", Adr, 32'h0);
        check("rst_zero", 32'(Zero), 32'h1);
        view(2'd0, 2'd0, 3'd0, 2'd3);
        check("rst_mulres", Adr, 32'h0);
        idle(); reset = 1; cyc();
        load_ir(32'h00500093);
        check("ir_load", Instr, 32'h00500093);
        view(2'd1, 2'd3, 3'd0, 2'd2);
        check("oldpc_load", Adr, 32'h100);

        // register file initialisation: x[i] = i << 12
        for (int i = 1; i < 16; i++) load_u(5'(i), 20'(i));
        read_reg(5'd9, v);
        check("x9_init", v, 32'h9000);

        // ADDI x1,x0,5 ; x0 write ; out-of-range write
        exec_addi(5'd1, 5'd0, 12'd5);
        read_reg(5'd1, v);
        check("addi_x1", v, 32'd5);
        exec_addi(5'd0, 5'd0, 12'h07B);
        read_reg(5'd0, v);
        check("x0_read", v, 32'd0);
        exec_addi(5'd20, 5'd0, 12'd9);
        read_reg(5'd20, v);
        check("x20_read", v, 32'd0);

        // DataWrite path
        idle(); ReadData = 32'hCAFEF00D; DataWrite = 1; cyc(); idle();
        view(2'd0, 2'd0, 3'd0, 2'd1);
        check("data_reg", Adr, 32'hCAFEF00D);

        // PCWrite and IRWrite together: OldPC sees pre-update PC
        idle(); ReadData = 32'h00000013; ALUSrcA = 2'd0; ALUSrcB = 2'd2; ResultSrc = 2'd2;
        PCWrite = 1; IRWrite = 1; cyc(); idle();
        view(2'd1, 2'd3, 3'd0, 2'd2);
        check("oldpc_same_cycle", Adr, 32'h100);
        idle(); #1;
        check("pc_plus4", Adr, 32'h104);

        // multiplies: A=7, B=-3
        exec_addi(5'd1, 5'd0, 12'd7);
        exec_addi(5'd2, 5'd0, 12'hFFD);
        load_ab(5'd1, 5'd2);
        check("b_operand", WriteData, 32'hFFFFFFFD);
        run_mul(2'd0, 0, lat, dones);
        check("mul_latency", 32'(lat), 32'd33);
        check("mul_dones", 32'(dones), 32'd1);
        view(2'd0, 2'd0, 3'd0, 2'd3);
        check("mul_result", Adr, 32'hFFFFFFEB);
        run_mul(2'd1, 0, lat, dones);
        view(2'd0, 2'd0, 3'd0, 2'd3);
        check("mulh_result", Adr, 32'hFFFFFFFF);
        run_mul(2'd3, 0, lat, dones);
        view(2'd0, 2'd0, 3'd0, 2'd3);
        check("mulhu_result", Adr, 32'h00000006);

        // MULHSU -1 x 2 with a stray MulStart and A/B reload during RUN
        exec_addi(5'd3, 5'd0, 12'hFFF);
        exec_addi(5'd4, 5'd0, 12'd2);
        load_ab(5'd3, 5'd4);
        run_mul(2'd2, 5, lat, dones);
        check("mulhsu_latency", 32'(lat), 32'd33);
        check("mulhsu_dones", 32'(dones), 32'd1);
        view(2'd0, 2'd0, 3'd0, 2'd3);
        check("mulhsu_result", Adr, 32'hFFFFFFFF);

        // reset during a multiply
        load_ab(5'd1, 5'd2);
        MulOp = 2'd0; MulStart = 1; cyc(); MulStart = 0;
        repeat (10) cyc();
        check("busy_mid_run", 32'(MulBusy), 32'd1);
        reset = 0; #1;
        check("abort_busy", 32'(MulBusy), 32'd0);
        view(2'd0, 2'd0, 3'd0, 2'd3);
        check("abort_mulres", Adr, 32'd0);
        idle(); cyc(); reset = 1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (MulDone) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);

        // immediates
        load_ir(32'h12345037);
        view(2'd3, 2'd1, 3'd4, 2'd2);
        check("imm_u", Adr, 32'h12345000);
        load_ir(32'hFF9FF06F);
        view(2'd3, 2'd1, 3'd3, 2'd2);
        check("imm_j", Adr, 32'hFFFFFFF8);
        load_ir(32'hFE000CE3);
        view(2'd3, 2'd1, 3'd2, 2'd2);
        check("imm_b", Adr, 32'hFFFFFFF8);
        load_ir(32'hFE000E23);
        view(2'd3, 2'd1, 3'd1, 2'd2);
        check("imm_s", Adr, 32'hFFFFFFFC);
        view(2'd3, 2'd1, 3'd5, 2'd2);
        check("imm_other", Adr, 32'h0);
        check("imm_other_zero", 32'(Zero), 32'd1);

        // PC wrap-around
        load_ir(32'hFFC00013);
        ALUSrcA = 2'd3; ALUSrcB = 2'd1; ImmSrc = 3'd0; ResultSrc = 2'd2; PCWrite = 1;
        cyc(); idle(); #1;
        check("pc_top", Adr, 32'hFFFFFFFC);
        ALUSrcA = 2'd0; ALUSrcB = 2'd2; ResultSrc = 2'd2; PCWrite = 1;
        cyc(); idle(); #1;
        check("pc_wrap", Adr, 32'h0);

        // ALU sweep with A=-1, B=2
        alu_exp = '{32'h00000001, 32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFF,
                    32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFC, 32'h3FFFFFFF,
                    32'hFFFFFFFF, 32'h00000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        load_ab(5'd3, 5'd4);
        for (int op = 0; op < 16; op++) begin
            ALUSrcA = 2'd2; ALUSrcB = 2'd0; ALUControl = 4'(op); ResultSrc = 2'd2; AdrSrc = 1;
            #1;
            check($sformatf("alu_op%0d", op), Adr, alu_exp[op]);
            cyc();
        end
        idle(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_datapath_xm.md
Name: mc_datapath_xm

Overview:
- Parametrised next-generation multi-cycle RISC-V datapath: XLEN-wide, configurable register count (RV32I/RV32E style) and reset vector.
- Adds enable-gated non-architectural registers, U/J immediates, and an iterative shift-add multiplier (M-extension MUL/MULH/MULHSU/MULHU) with a start/busy/done handshake toward the controller FSM.
- Sits between the multi-cycle controller and the unified instruction/data memory.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- NREGS, 32, architectural registers; legal values 16 and 32.
- RESET_PC, 0, PC value on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- PCWrite  in  1  load PC from Result.
- AdrSrc  in  1  memory address select: 0 = PC, 1 = Result.
- IRWrite  in  1  load Instr from ReadData and OldPC from PC.
- RegWrite  in  1  write Result to Instr[11:7].
- ImmSrc  in  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U; others give 0.
- ALUSrcA  in  2  SrcA select: 00 PC, 01 OldPC, 10 A register, 11 zero.
- ALUSrcB  in  2  SrcB select: 00 B register, 01 ImmExt, 10 constant 4, 11 zero.
- ALUControl  in  4  ALU op; same encoding as the existing core ALU, extended to XLEN.
- ResultSrc  in  2  Result select: 00 ALUOut, 01 Data, 10 ALUResult, 11 MulResult.
- ABWrite, OutWrite, DataWrite  in  1 each  enables for the A/B, ALUOut and Data registers.
- MulStart  in  1  start a multiply using the A and B registers.
- MulOp  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- ReadData  in  XLEN  memory read data.
- Adr  out  XLEN  memory address.
- WriteData  out  XLEN  B register, used as store data.
- Instr  out  32  instruction register, to the controller.
- Zero  out  1  ALUResult == 0, combinational.
- MulBusy  out  1  multiplier running.
- MulDone  out  1  one-cycle completion pulse.

Behaviour:
- Reset asserted (async): PC = RESET_PC; OldPC, Instr, A, B, ALUOut, Data, MulResult = 0; MulBusy = MulDone = 0.
- Register file is not reset.
- Register file:
  - Reads of x0 return 0.
  - Reads and writes to index >= NREGS return 0 and are dropped.
  - Write is synchronous.
  - Read is combinational and shows the old value in the write cycle (no bypass).
- A, B, ALUOut and Data load only when their enable is 1; otherwise they hold.
- Immediates sign-extend to XLEN; U-type forms imm[31:12]<<12, sign-extended when XLEN = 64.
- PC and IRWrite in the same cycle: OldPC captures the pre-update PC.
- Multiplier state machine, IDLE -> RUN -> DONE -> IDLE:
  - IDLE: MulStart = 1 latches A, B and MulOp, sets MulBusy = 1 next cycle, and moves to RUN.
  - RUN: exactly XLEN cycles; one multiplicand-magnitude bit per cycle on a 2*XLEN accumulator.
  - DONE: applies sign correction. Operands are signed for MULH (both) and MULHSU (rs1 only).
  - DONE: MulResult = low XLEN bits for MUL, high XLEN bits otherwise. MulDone = 1 and MulBusy = 0 for one cycle, then IDLE.
  - Total latency: MulStart edge to MulDone high = XLEN+1 cycles.
  - MulResult holds until the next completion.
- MulStart while RUN or DONE: ignored, operation unaffected.
- A/B rewritten during RUN: no effect on the operation in flight.
- Reset mid-multiply: aborts; MulBusy = 0 and MulResult = 0 immediately.
- Wrap-around: arithmetic is modulo 2^XLEN, and PC+4 wraps silently.

Test Plan:
- Reset: reset = 0 with RESET_PC = 32'h100 -> PC = Adr = 32'h100, all registers 0, MulBusy = 0; release, then IRWrite with ReadData = 32'h00500093 -> Instr = 32'h00500093, OldPC = 32'h100.
- ADDI x1,x0,5 sequence (IRWrite, ABWrite, SrcA = A, SrcB = Imm, OutWrite, RegWrite with ResultSrc = 00) -> x1 = 5; write to x0 -> x0 reads 0; NREGS = 16 write to x20 -> read returns 0.
- MUL with A = 7, B = -3 (32'hFFFFFFFD) -> MulDone exactly 33 cycles after MulStart, MulResult = 32'hFFFFFFEB; MULH with same operands -> 32'hFFFFFFFF; MULHU -> 32'h00000006.
- MULHSU with A = -1, B = 2 -> 32'hFFFFFFFF; MulStart pulsed again at cycle 5 of RUN -> ignored, single MulDone, result unchanged.
- Reset asserted at cycle 10 of a multiply -> MulBusy drops the same cycle, no MulDone, MulResult = 0.
- Immediates: ImmSrc = 100 with Instr = 32'h12345037 -> ImmExt = 32'h12345000; ImmSrc = 011 with JAL -8 -> ImmExt = 32'hFFFFFFF8; PC = 32'hFFFFFFFC + 4 -> 0.
